game_tick_scheduler: RTL and testbench



---
 rtl/game_tick_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_game_tick_scheduler.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// Game timing controller: derives the pixel enable, the 1 Hz second tick and the
// level-dependent lane-move tick as one-cycle clock enables, and sequences game
// state (idle/run/pause/over).
// Optional feature: define SCHED_STEP_EN to add a single-step move input used in PAUSE.
module game_tick_scheduler #(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned PIX_DIV       = 4,
    parameter int unsigned BASE_MOVE_DIV = 50_000_000,
    parameter int unsigned MOVE_STEP     = 5_000_000,
    parameter int unsigned MIN_MOVE_DIV  = 10_000_000,
    parameter int unsigned LEVEL_SECS    = 10,
    parameter int unsigned MAX_LEVEL     = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       pause_i,
    input  logic       crash_i,
`ifdef SCHED_STEP_EN
    input  logic       step_i,
`endif
    output logic       pix_en_o,
    output logic       sec_tick_o,
    output logic       move_tick_o,
    output logic [2:0] level_o,
    output logic [9:0] elapsed_s_o,
    output logic       running_o,
    output logic       game_over_o
);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StOver} state_e;

    state_e      state_q, state_d;
    logic        running_q, running_d;
    logic        game_over_q, game_over_d;
    logic [31:0] pix_cnt_q;
    logic        pix_en_q;
    logic [31:0] sec_cnt_q, sec_cnt_d;
    logic [31:0] move_cnt_q, move_cnt_d;
    logic [31:0] move_div_q, move_div_d;
    logic [31:0] lsec_q, lsec_d;
    logic [2:0]  level_q, level_d;
    logic [9:0]  elapsed_q, elapsed_d;
    logic        sec_tick_q, sec_tick_d;
    logic        move_tick_q, move_tick_d;
    logic        clr, adv, sec_wrap, move_wrap, step_fire;

    // Move period for a level; the reduction is compared before subtracting so a
    // large level never wraps the unsigned result.
    function automatic logic [31:0] move_div_f(input logic [2:0] lvl);
        logic [31:0] red;
        red = 32'(lvl) * MOVE_STEP;
        if (red < BASE_MOVE_DIV && (BASE_MOVE_DIV - red) > MIN_MOVE_DIV) begin
            return BASE_MOVE_DIV - red;
        end
        return MIN_MOVE_DIV;
    endfunction

    // State register plus registered status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            running_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            running_q   <= running_d;
            game_over_q <= game_over_d;
        end
    end

    // Next-state logic; priority crash > pause > start where each applies.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StRun;
            StRun: begin
                if (crash_i)      state_d = StOver;
                else if (pause_i) state_d = StPause;
            end
            StPause: begin
                if (crash_i)                 state_d = StOver;
                else if (pause_i || start_i) state_d = StRun;
            end
            StOver:  if (start_i) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // Output/control decode: counter clear, counter advance and strobe requests.
    always_comb begin
        running_d   = (state_d == StRun);
        game_over_d = (state_d == StOver);
        if (state_q == StRun || state_q == StPause) begin
            clr = start_i && !pause_i && !crash_i;
        end else begin
            clr = start_i;
        end
        // Counters only move on a quiet RUN cycle; a wrap under crash is dropped.
        adv       = (state_q == StRun) && !crash_i && !pause_i && !start_i;
        sec_wrap  = adv && (sec_cnt_q == CLK_HZ - 1);
        move_wrap = adv && (move_cnt_q == move_div_q - 32'd1);
`ifdef SCHED_STEP_EN
        step_fire = (state_q == StPause) && step_i && !pause_i && !crash_i && !start_i;
`else
        step_fire = 1'b0;
`endif
        sec_tick_d  = sec_wrap;
        move_tick_d = move_wrap || step_fire;
    end

    // Free-running pixel enable divider, independent of game state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pix_cnt_q <= '0;
            pix_en_q  <= 1'b0;
        end else begin
            pix_cnt_q <= (pix_cnt_q == PIX_DIV - 1) ? '0 : pix_cnt_q + 32'd1;
            pix_en_q  <= (pix_cnt_q == PIX_DIV - 1);
        end
    end

    // Next values for game counters, level and elapsed time.
    always_comb begin
        sec_cnt_d  = sec_cnt_q;
        move_cnt_d = move_cnt_q;
        move_div_d = move_div_q;
        lsec_d     = lsec_q;
        level_d    = level_q;
        elapsed_d  = elapsed_q;
        if (clr) begin
            sec_cnt_d  = '0;
            move_cnt_d = '0;
            move_div_d = move_div_f(3'd0);
            lsec_d     = '0;
            level_d    = '0;
            elapsed_d  = '0;
        end else if (adv) begin
            sec_cnt_d = sec_wrap ? '0 : sec_cnt_q + 32'd1;
            if (move_wrap) begin
                move_cnt_d = '0;
                // Latch with the level in force now; a same-edge level change
                // applies from the following period.
                move_div_d = move_div_f(level_q);
            end else begin
                move_cnt_d = move_cnt_q + 32'd1;
            end
            if (sec_wrap) begin
                if (elapsed_q != 10'd999) elapsed_d = elapsed_q + 10'd1;
                if (lsec_q == LEVEL_SECS - 1) begin
                    lsec_d = '0;
                    if (level_q != 3'(MAX_LEVEL)) level_d = level_q + 3'd1;
                end else begin
                    lsec_d = lsec_q + 32'd1;
                end
            end
        end
    end

    // Game counter and strobe registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sec_cnt_q   <= '0;
            move_cnt_q  <= '0;
            move_div_q  <= move_div_f(3'd0);
            lsec_q      <= '0;
            level_q     <= '0;
            elapsed_q   <= '0;
            sec_tick_q  <= 1'b0;
            move_tick_q <= 1'b0;
        end else begin
            sec_cnt_q   <= sec_cnt_d;
            move_cnt_q  <= move_cnt_d;
            move_div_q  <= move_div_d;
            lsec_q      <= lsec_d;
            level_q     <= level_d;
            elapsed_q   <= elapsed_d;
            sec_tick_q  <= sec_tick_d;
            move_tick_q <= move_tick_d;
        end
    end

    assign pix_en_o    = pix_en_q;
    assign sec_tick_o  = sec_tick_q;
    assign move_tick_o = move_tick_q;
    assign level_o     = level_q;
    assign elapsed_s_o = elapsed_q;
    assign running_o   = running_q;
    assign game_over_o = game_over_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with small timing parameters.
module tb_game_tick_scheduler;

    logic       clk, rst, start, pause, crash;
`ifdef SCHED_STEP_EN
    logic       step;
`endif
    logic       pix_en, sec_tick, move_tick, running, game_over;
    logic [2:0] level;
    logic [9:0] elapsed_s;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    game_tick_scheduler #(
        .CLK_HZ        (20),
        .PIX_DIV       (4),
        .BASE_MOVE_DIV (10),
        .MOVE_STEP     (2),
        .MIN_MOVE_DIV  (4),
        .LEVEL_SECS    (2),
        .MAX_LEVEL     (7)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .pause_i     (pause),
        .crash_i     (crash),
`ifdef SCHED_STEP_EN
        .step_i      (step),
`endif
        .pix_en_o    (pix_en),
        .sec_tick_o  (sec_tick),
        .move_tick_o (move_tick),
        .level_o     (level),
        .elapsed_s_o (elapsed_s),
        .running_o   (running),
        .game_over_o (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        logic seen;
        rst = 1'b1; start = 1'b0; pause = 1'b0; crash = 1'b0;
`ifdef SCHED_STEP_EN
        step = 1'b0;
`endif
        repeat (3) tick();
        check("rst_pix_en", pix_en, 0);
        check("rst_sec_tick", sec_tick, 0);
        check("rst_move_tick", move_tick, 0);
        check("rst_running", running, 0);
        check("rst_game_over", game_over, 0);
        check("rst_level", level, 0);
        check("rst_elapsed", elapsed_s, 0);
        rst = 1'b0;

        // 1: idle, pix_en every 4th cycle, no game strobes
        for (int i = 1; i <= 40; i++) begin
            tick();
            check("idle_pix_en", pix_en, (i % 4 == 0));
            check("idle_strobes", {sec_tick, move_tick, running}, 0);
        end

        // 2: start, first move/sec periods, first level change
        start = 1'b1; tick(); start = 1'b0;
        check("start_running", running, 1);
        check("start_level", level, 0);
        for (int j = 1; j <= 60; j++) begin
            tick();
            check("run_move_tick", move_tick,
                  (j == 10 || j == 20 || j == 30 || j == 40 || j == 50 || j == 58));
            check("run_sec_tick", sec_tick, (j == 20 || j == 40 || j == 60));
            if (j == 20) check("elapsed_1", elapsed_s, 1);
            if (j == 39) check("level_before", level, 0);
            if (j == 40) check("level_after", level, 1);
            if (j == 60) check("elapsed_3", elapsed_s, 3);
        end

        // 3: 20 s of running; level saturates and move period floors at 4
        for (int j = 61; j <= 400; j++) tick();
        check("sat_level", level, 7);
        check("sat_elapsed", elapsed_s, 20);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (move_tick) begin
                seen = 1'b1;
                break;
            end
        end
        check("move_seen", seen, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n++;
            if (move_tick) break;
        end
        check("move_period_min", n, 4);
        check("level_hold_7", level, 7);

        // 4: pause 7 cycles into a second, resume, 13 cycles to the tick
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (sec_tick) begin
                seen = 1'b1;
                break;
            end
        end
        check("sec_seen", seen, 1);
        check("elapsed_21", elapsed_s, 21);
        repeat (7) tick();
        pause = 1'b1; tick(); pause = 1'b0;
        check("pause_running", running, 0);
        check("pause_edge_strobes", {sec_tick, move_tick}, 0);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("paused_strobes", {sec_tick, move_tick}, 0);
        end
        check("paused_elapsed", elapsed_s, 21);
        pause = 1'b1; tick(); pause = 1'b0;
        check("resume_running", running, 1);
        for (int j = 1; j <= 13; j++) begin
            tick();
            check("resume_sec_tick", sec_tick, (j == 13));
        end
        check("elapsed_22", elapsed_s, 22);

        // 5: crash on the wrap cycle discards the tick and freezes state
        repeat (19) tick();
        check("pre_crash_sec_tick", sec_tick, 0);
        crash = 1'b1; tick(); crash = 1'b0;
        check("crash_sec_tick", sec_tick, 0);
        check("crash_game_over", game_over, 1);
        check("crash_running", running, 0);
        repeat (10) tick();
        check("over_elapsed", elapsed_s, 22);
        check("over_level", level, 7);
        check("over_strobes", {sec_tick, move_tick}, 0);
        pause = 1'b1; tick(); pause = 1'b0;
        check("over_pause_ignored", game_over, 1);
        start = 1'b1; tick(); start = 1'b0;
        check("restart_running", running, 1);
        check("restart_game_over", game_over, 0);
        check("restart_level", level, 0);
        check("restart_elapsed", elapsed_s, 0);

        // 6: reset mid-run, then start+pause priority
        repeat (25) tick();
        check("pre_rst_elapsed", elapsed_s, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_running", running, 0);
        check("midrst_game_over", game_over, 0);
        check("midrst_level", level, 0);
        check("midrst_elapsed", elapsed_s, 0);
        check("midrst_strobes", {pix_en, sec_tick, move_tick}, 0);
        start = 1'b1; pause = 1'b1; tick(); start = 1'b0; pause = 1'b0;
        check("idle_start_pause", running, 1);
        tick();
        start = 1'b1; pause = 1'b1; tick(); start = 1'b0; pause = 1'b0;
        check("run_start_pause", running, 0);
        check("run_start_pause_over", game_over, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
